pipeline_stage_reg: RTL and testbench

PIPELINE_STAGE_REG -- requirements
Module: pipeline_stage_reg

---
 rtl/pipeline_pkg.sv | 51 +++++
 rtl/sat_counter.sv | 34 +++
 rtl/pipeline_stage_reg.sv | 143 ++++++++++++++
 tb/tb_pipeline_stage_reg.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: stage occupancy states, the NOP bubble
// instruction and packed payload layouts for the stage boundaries.
package pipeline_pkg;

  // Occupancy of a pipeline stage register (number of entries held).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  // ADDI x0,x0,0 -- the bubble presented downstream while a stage is empty.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // Packed payloads carried across each boundary by one stage register.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] wb_val;
    logic [4:0]  rd;
  } mem_wb_t;

  // Number of live entries held in a given occupancy state.
  function automatic logic [1:0] entries_held(stage_state_e s);
    logic [1:0] n;
    case (s)
      BUSY:    n = 2'd1;
      FULL:    n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: adds inc (0..3) when en is high and sticks at
// the all-ones value instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W:0]   sum_next;

  // One extra bit catches the carry that signals saturation.
  always_comb begin
    sum_next = {1'b0, count_reg} + (CNT_W + 1)'(inc);
  end

  // Counter register: clamp at CNT_MAX whenever the sum overflows CNT_W bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= sum_next[CNT_W] ? CNT_MAX : sum_next[CNT_W-1:0];
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipeline_stage_reg.sv
// Two-entry (main + skid) pipeline stage register with valid/ready
// handshakes, flush support and stall/drop statistics. in_ready is a
// registered function of occupancy, so there is no combinational path
// from out_ready back upstream.
module pipeline_stage_reg
  import pipeline_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] FLUSH_VAL = DATA_W'(NOP_INSN),
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  stage_state_e      state_reg, state_next;
  logic              in_ready_reg;
  logic [DATA_W-1:0] main_reg;
  logic [DATA_W-1:0] skid_reg;

  logic accept;
  logic consume;
  logic load_main_in;    // main <- in_data
  logic load_main_skid;  // main <- skid (skid drains into head)
  logic load_skid;       // skid <- in_data

  logic       stall_en;
  logic [1:0] drop_inc;

  assign out_valid = (state_reg != EMPTY);
  assign in_ready  = in_ready_reg;
  assign accept    = in_valid & in_ready_reg;
  assign consume   = out_valid & out_ready;

  // Next-state and register-load decode; flush overrides any handshake.
  always_comb begin
    state_next     = state_reg;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            state_next   = BUSY;
            load_main_in = 1'b1;
          end
        end
        BUSY: begin
          case ({accept, consume})
            2'b11: load_main_in = 1'b1;
            2'b10: begin
              state_next = FULL;
              load_skid  = 1'b1;
            end
            2'b01: state_next = EMPTY;
            default: state_next = BUSY;
          endcase
        end
        FULL: begin
          // in_ready is low here, so only a consume can move the state.
          if (consume) begin
            state_next     = BUSY;
            load_main_skid = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // State register plus the registered copy of in_ready for the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= EMPTY;
      in_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next != FULL);
    end
  end

  // Payload registers; each only changes when explicitly loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_reg <= FLUSH_VAL;
      skid_reg <= FLUSH_VAL;
    end else begin
      if (load_main_in) begin
        main_reg <= in_data;
      end else if (load_main_skid) begin
        main_reg <= skid_reg;
      end
      if (load_skid) begin
        skid_reg <= in_data;
      end
    end
  end

  // Present the NOP bubble whenever nothing live is held.
  always_comb begin
    out_data = (state_reg == EMPTY) ? FLUSH_VAL : main_reg;
  end

  // Statistics qualifiers: a flush cycle is never counted as a stall, and a
  // flush drops exactly the entries held before the edge.
  always_comb begin
    stall_en = out_valid & ~out_ready & ~flush;
    drop_inc = entries_held(state_reg);
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (stall_en),
    .inc   (2'd1),
    .count (stall_cnt)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (flush),
    .inc   (drop_inc),
    .count (drop_cnt)
  );

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Scoreboard bench for pipeline_stage_reg: the driver pushes every accepted
// payload into an expected FIFO; a negedge monitor compares the DUT outputs
// against that FIFO and against counter values derived from the handshake
// rules, popping on each consume.
module tb_pipeline_stage_reg;

  localparam int          DATA_W  = 32;
  localparam int          CNT_W   = 4;
  localparam int          CNT_MAX = 15;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              flush = 1'b0;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  drop_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model: live entries in arrival order plus expected counters.
  logic [DATA_W-1:0] exp_q[$];
  int stall_exp = 0;
  int drop_exp  = 0;

  pipeline_stage_reg #(
    .DATA_W    (DATA_W),
    .FLUSH_VAL (NOP),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .stall_cnt (stall_cnt),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are stable at the falling edge; check, then advance
  // the model by the transfer that the coming rising edge will perform.
  always @(negedge clk) begin
    int sz;
    if (rst === 1'b0) begin
      sz = exp_q.size();
      chk("out_valid", {31'd0, out_valid}, {31'd0, sz > 0});
      chk("in_ready", {31'd0, in_ready}, {31'd0, sz < 2});
      if (sz > 0) chk("out_data", out_data, exp_q[0]);
      else        chk("out_data_nop", out_data, NOP);
      chk("stall_cnt", 32'(stall_cnt), 32'(stall_exp));
      chk("drop_cnt", 32'(drop_cnt), 32'(drop_exp));
      if (flush) begin
        drop_exp = sat(drop_exp + sz);
        exp_q.delete();
      end else if (sz > 0) begin
        if (out_ready) void'(exp_q.pop_front());
        else           stall_exp = sat(stall_exp + 1);
      end
    end
  end

  // One cycle of stimulus; called just after a rising edge. An accepted
  // payload joins the expected FIFO once the edge has taken it.
  task automatic step(input logic v, input logic [31:0] d, input logic r, input logic f);
    bit acc;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    acc = v && !f && (exp_q.size() < 2);
    @(posedge clk);
    #1;
    if (acc) exp_q.push_back(d);
  endtask

  // Asynchronous reset mid-cycle; outputs must take reset values at once.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, NOP);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    exp_q.delete();
    stall_exp = 0;
    drop_exp  = 0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // Streaming: 1..8 back to back, each visible one cycle after acceptance.
    for (int i = 1; i <= 8; i++) step(1'b1, 32'(i), 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    chk("stream_stall_cnt", 32'(stall_cnt), 32'd0);
    $display("stream: 8 entries, stall_cnt=%0d", stall_cnt);

    // Backpressure: two entries fill the stage, then drain in order.
    do_reset();
    step(1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0);
    chk("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_full_out_data", out_data, 32'hA);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    chk("bp_second_out", out_data, 32'hB);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    chk("bp_stall_cnt", 32'(stall_cnt), 32'd2);
    $display("backpressure: stall_cnt=%0d", stall_cnt);

    // Flush while FULL with a new input offered: everything discarded.
    do_reset();
    step(1'b1, 32'h11, 1'b0, 1'b0);
    step(1'b1, 32'h22, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD, 1'b0, 1'b1);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_out_data", out_data, NOP);
    chk("flush_drop_cnt", 32'(drop_cnt), 32'd2);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    $display("flush: drop_cnt=%0d", drop_cnt);

    // Saturation: stall for 20 cycles on a 4-bit counter.
    do_reset();
    step(1'b1, 32'h5, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 32'd0, 1'b0, 1'b0);
    chk("sat_stall_cnt", 32'(stall_cnt), 32'd15);
    $display("saturation: stall_cnt=%0d", stall_cnt);

    // Reset while FULL: outputs return to reset values before the next edge.
    do_reset();
    step(1'b1, 32'h1, 1'b0, 1'b0);
    step(1'b1, 32'h2, 1'b0, 1'b0);
    do_reset();
    $display("reset in FULL: drop_cnt=%0d", drop_cnt);

    // Randomised traffic with periodic resets to keep counters in range.
    for (int i = 0; i < 1500; i++) begin
      if (i % 200 == 199) do_reset();
      step($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
           $urandom_range(0, 19) == 0);
    end
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    $display("random: 1500 cycles, stall_cnt=%0d drop_cnt=%0d", stall_cnt, drop_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
